// File: rtl/c_requant_drain_if.sv
// c_requant_drain_if
//   Bundles the control, C-buffer read and output-stream signals of c_requant_drain.
//   master : the drain block (drives busy/done, read strobe/index, output stream)
//   slave  : the surrounding system (drives start/parameters, C read data, out_ready)
//
// Handshake: the output stream transfers a word on every rising clk edge where
// out_valid & out_ready are both high. Once out_valid is high it stays high, and
// out_data/out_last stay unchanged, until that transfer happens. out_ready may
// change freely and never depends combinationally on out_valid.
// The C buffer returns C_data_out exactly one cycle after a cycle with C_rd_en=1.
interface c_requant_drain_if #(
    parameter int LANES = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
);
    logic                     start;
    logic [15:0]              word_count;
    logic [4:0]               shift;
    logic [OUT_W-1:0]         zero_point;
    logic                     busy;
    logic                     done;
    logic                     C_rd_en;
    logic [15:0]              C_index;
    logic [LANES*ACC_W-1:0]   C_data_out;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   out_data;
    logic                     out_last;
    logic [1:0]               dbg_state;

    modport master (
        input  start, word_count, shift, zero_point, C_data_out, out_ready,
        output busy, done, C_rd_en, C_index, out_valid, out_data, out_last, dbg_state
    );

    modport slave (
        output start, word_count, shift, zero_point, C_data_out, out_ready,
        input  busy, done, C_rd_en, C_index, out_valid, out_data, out_last, dbg_state
    );
endinterface

// File: rtl/c_requant_drain.sv
// c_requant_drain
//   Reads word_count 128-bit words (LANES x int32 accumulators) from the C buffer,
//   requantizes every lane to int8 (rounding arithmetic right shift, zero-point add,
//   saturation) and streams the packed result through a small output FIFO.
// Ports
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : c_requant_drain_if.master
//            start/word_count/shift/zero_point : launch a drain (parameters sampled at start)
//            busy/done                         : status, done is a one-cycle pulse
//            C_rd_en/C_index/C_data_out        : C buffer read port, 1-cycle read latency
//            out_valid/out_ready/out_data/out_last : output stream
//            dbg_state                         : current FSM state (0 idle, 1 run, 2 flush, 3 done)
module c_requant_drain #(
    parameter int FIFO_DEPTH = 4,
    parameter int LANES      = 4,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    c_requant_drain_if.master  bus
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = CNT_W + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WORD_W = LANES * OUT_W;
    // Two guard bits: acc + rounding constant and t + zero_point can never overflow.
    localparam int IW     = ACC_W + 2;

    localparam logic signed [IW-1:0] Q_MAX = IW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IW-1:0] Q_MIN = ~Q_MAX;  // two's complement: ~127 == -128

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [15:0]      wc_q;
    logic [4:0]       shift_q;
    logic [OUT_W-1:0] zp_q;
    logic [15:0]      issue_idx_q;   // index of the next read to issue
    logic [15:0]      last_idx_q;    // index of the most recently issued read
    logic             inflight_q;    // a read issued last cycle returns data this cycle
    logic             inflight_last_q;

    logic [WORD_W:0]  fifo_mem [FIFO_DEPTH];  // bit WORD_W carries out_last
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             push, pop, rd_en, is_last_issue;
    logic [OCC_W-1:0] occupancy;
    logic [WORD_W-1:0] quant_word;
    logic [WORD_W:0]  head;

    function automatic logic [OUT_W-1:0] requant(
        input logic [ACC_W-1:0] acc,
        input logic [4:0]       sh,
        input logic [OUT_W-1:0] zp
    );
        logic signed [IW-1:0] a, rnd, t, q;
        logic [OUT_W-1:0]     r;
        a   = {{(IW-ACC_W){acc[ACC_W-1]}}, acc};
        rnd = (sh == 5'd0) ? '0 : (IW'(1) << (sh - 5'd1));
        t   = (a + rnd) >>> sh;
        q   = t + {{(IW-OUT_W){zp[OUT_W-1]}}, zp};
        if (q > Q_MAX)      r = Q_MAX[OUT_W-1:0];
        else if (q < Q_MIN) r = Q_MIN[OUT_W-1:0];
        else                r = q[OUT_W-1:0];
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Issue rule: FIFO entries plus the read in flight, minus a word leaving this
    // cycle, must leave room for the new read. Counting the pop keeps 1 word/cycle.
    always_comb begin
        pop           = (count_q != '0) && bus.out_ready;
        push          = inflight_q;
        is_last_issue = (issue_idx_q == wc_q - 16'd1);
        occupancy     = {1'b0, count_q} + OCC_W'(inflight_q) - OCC_W'(pop);
        rd_en         = (state_q == S_RUN) && (occupancy < OCC_W'(FIFO_DEPTH));
        head          = fifo_mem[rd_ptr_q];
    end

    always_comb begin
        quant_word = '0;
        for (int i = 0; i < LANES; i++) begin
            quant_word[i*OUT_W +: OUT_W] = requant(bus.C_data_out[i*ACC_W +: ACC_W], shift_q, zp_q);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = (bus.word_count == 16'd0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (rd_en && is_last_issue) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                // FIFO counts as empty when its last word leaves this cycle.
                if (!inflight_q && (count_q == CNT_W'(pop))) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        bus.C_rd_en   = rd_en;
        bus.C_index   = rd_en ? issue_idx_q : last_idx_q;
        bus.out_valid = (count_q != '0);
        bus.out_data  = head[WORD_W-1:0];
        bus.out_last  = head[WORD_W];
        bus.dbg_state = state_q;
    end

    // Drain parameters, captured only when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_q    <= '0;
            shift_q <= '0;
            zp_q    <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            wc_q    <= bus.word_count;
            shift_q <= bus.shift;
            zp_q    <= bus.zero_point;
        end
    end

    // Read address generation and the one-deep read-latency tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_idx_q     <= '0;
            last_idx_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && is_last_issue;
            if (state_q == S_IDLE && bus.start) begin
                issue_idx_q <= '0;
            end else if (rd_en) begin
                issue_idx_q <= issue_idx_q + 16'd1;
                last_idx_q  <= issue_idx_q;
            end
        end
    end

    // Output FIFO. A push never finds it full: the slot was reserved at issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= {inflight_last_q, quant_word};
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_c_requant_drain.sv
// tb_c_requant_drain
//   Directed bench for c_requant_drain. A word-level model turns the C buffer
//   contents and the drain parameters into the expected output words, and one
//   monitor compares the output stream and read order against it every cycle.
//   Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_c_requant_drain;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    c_requant_drain_if bus ();

    c_requant_drain dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- C buffer model (1-cycle read latency) ----------------
    logic [127:0] cmem [0:15];
    always @(posedge clk) if (bus.C_rd_en) bus.C_data_out <= cmem[bus.C_index[3:0]];

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    logic [32:0] exp_q [$];   // {last, word}
    int          next_idx, issued, accepted, done_cnt, valid_cnt;
    int          last_acc_cyc, done_cyc;
    logic        prev_stall;
    logic [32:0] prev_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] q8(input logic [31:0] acc, input int sh, input logic [7:0] zp);
        longint a, t, q;
        a = longint'($signed(acc));
        if (sh > 0) a = a + (longint'(1) << (sh - 1));
        t = a >>> sh;
        q = t + longint'($signed(zp));
        if (q > 127) q = 127;
        else if (q < -128) q = -128;
        return q[7:0];
    endfunction

    function automatic logic [31:0] model_word(input logic [127:0] c, input int sh, input logic [7:0] zp);
        logic [31:0] w;
        for (int l = 0; l < 4; l++) w[8*l +: 8] = q8(c[32*l +: 32], sh, zp);
        return w;
    endfunction

    function automatic logic [127:0] mk(input int l3, input int l2, input int l1, input int l0);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.C_rd_en) begin
                check("rd_index", 64'(bus.C_index), 64'(next_idx));
                next_idx++;
                issued++;
            end
            if (bus.out_valid) valid_cnt++;
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_word", 64'({bus.out_last, bus.out_data}), 64'(prev_word));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h, expected no word", bus.out_data);
                end else begin
                    logic [32:0] w;
                    w = exp_q.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(w[31:0]));
                    check("out_last", 64'(bus.out_last), 64'(w[32]));
                end
                accepted++;
                last_acc_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            check("outstanding", 64'(issued - accepted <= FIFO_DEPTH), 64'd1);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = {bus.out_last, bus.out_data};
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the falling edge of cycle 1 (start is high in cycle 0).
    task automatic start_drain(input int wc, input int sh, input logic [7:0] zp);
        for (int i = 0; i < wc; i++) exp_q.push_back({(i == wc - 1), model_word(cmem[i], sh, zp)});
        next_idx = 0; issued = 0; accepted = 0; done_cnt = 0; valid_cnt = 0;
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.word_count = wc[15:0];
        bus.shift      = sh[4:0];
        bus.zero_point = zp;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done_cnt == 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done_timeout: got no done, expected done within 300 cycles", name);
        end
        repeat (3) @(negedge clk);
        check({name, "_done_once"}, 64'(done_cnt), 64'd1);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_idle"}, 64'(bus.busy), 64'd0);
        check({name, "_done_after_accept"}, 64'((done_cyc - last_acc_cyc >= 1) && (done_cyc - last_acc_cyc <= 2)), 64'd1);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_busy"}, 64'(bus.busy), 64'd0);
        check({name, "_done"}, 64'(bus.done), 64'd0);
        check({name, "_rd_en"}, 64'(bus.C_rd_en), 64'd0);
        check({name, "_index"}, 64'(bus.C_index), 64'd0);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_data"}, 64'(bus.out_data), 64'd0);
        check({name, "_last"}, 64'(bus.out_last), 64'd0);
    endtask

    // ---------------- global watchdog ----------------
    initial begin
        #400000;
        $display("FAIL global_timeout: got no end of test, expected end before 400000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.shift      = '0;
        bus.zero_point = '0;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < 16; i++) cmem[i] = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Model pins: hand-computed words.
        check("pin_t1", 64'(model_word(mk(-128, 127, -3, 5), 0, 8'd0)), 64'h807FFD05);
        check("pin_t2", 64'(model_word(mk(0, 23, -24, 24), 4, 8'd3)), 64'h03040205);
        check("pin_t3", 64'(model_word(mk(-129, 127, -100000, 100000), 0, 8'd0)), 64'h807F807F);
        check("pin_zp", 64'(model_word(mk(-1, 0, 127, -128), 0, 8'hFF)), 64'hFEFF7E80);
        check("pin_sh31", 64'(model_word(mk(32'h3FFFFFFF, 32'h40000000, 32'h7FFFFFFF, 32'h80000000), 31, 8'd0)), 64'h000101FF);

        // T1: single word, exact timing.
        cmem[0] = mk(-128, 127, -3, 5);
        start_drain(1, 0, 8'd0);
        check("t1_rd_en_c1", 64'(bus.C_rd_en), 64'd1);
        check("t1_index_c1", 64'(bus.C_index), 64'd0);
        check("t1_busy_c1", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("t1_rd_en_c2", 64'(bus.C_rd_en), 64'd0);
        check("t1_valid_c2", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("t1_valid_c3", 64'(bus.out_valid), 64'd1);
        check("t1_data_c3", 64'(bus.out_data), 64'h807FFD05);
        check("t1_last_c3", 64'(bus.out_last), 64'd1);
        wait_done("t1");

        // T2: rounding.
        cmem[0] = mk(0, 23, -24, 24);
        start_drain(1, 4, 8'd3);
        wait_done("t2");

        // T3: saturation, negative zero point, largest shift.
        cmem[0] = mk(-129, 127, -100000, 100000);
        start_drain(1, 0, 8'd0);
        wait_done("t3a");
        cmem[0] = mk(-1, 0, 127, -128);
        start_drain(1, 0, 8'hFF);
        wait_done("t3b");
        cmem[0] = mk(32'h3FFFFFFF, 32'h40000000, 32'h7FFFFFFF, 32'h80000000);
        start_drain(1, 31, 8'd0);
        wait_done("t3c");

        // T4: backpressure, plus a start while busy that must be ignored.
        for (int i = 0; i < 8; i++) cmem[i] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        start_drain(8, $urandom_range(1, 12), 8'($urandom_range(0, 255)));
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.word_count = 16'd3;
        bus.shift      = 5'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("t4_stall_issued", 64'(issued), 64'(FIFO_DEPTH));
        check("t4_stall_valid", 64'(bus.out_valid), 64'd1);
        check("t4_stall_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_done("t4");
        check("t4_issued_total", 64'(issued), 64'd8);

        // T4b: steady state, 8 words back to back.
        for (int i = 0; i < 8; i++) cmem[i] = {$urandom, $urandom, $urandom, $urandom};
        start_drain(8, 2, 8'd250);
        wait_done("t4b");
        check("t4b_no_bubbles", 64'(last_acc_cyc - done_cyc + 8), 64'd7);

        // T5: zero words.
        start_drain(0, 0, 8'd0);
        check("t5_done_c1", 64'(bus.done), 64'd1);
        check("t5_busy_c1", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("t5_done_c2", 64'(bus.done), 64'd0);
        check("t5_busy_c2", 64'(bus.busy), 64'd0);
        repeat (4) @(negedge clk);
        check("t5_no_reads", 64'(issued), 64'd0);
        check("t5_no_valid", 64'(valid_cnt), 64'd0);
        check("t5_done_once", 64'(done_cnt), 64'd1);

        // T6: reset in the middle of a run, then a clean run.
        for (int i = 0; i < 8; i++) cmem[i] = {$urandom, $urandom, $urandom, $urandom};
        start_drain(8, 5, 8'd7);
        begin
            int k = 0;
            while (issued < 3 && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        check("t6_reads_before_reset", 64'(issued >= 3), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cmem[0] = mk(1000, -1000, 64, -65);
        cmem[1] = mk(-7, 7, 300, -300);
        start_drain(2, 3, 8'd1);
        wait_done("t6b");
        check("t6b_words", 64'(accepted), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
